// File: rtl/conv_postproc.sv
// Conv post-processing: leaky ReLU, requantize to u8 with zero point, pack 8 lanes, show-ahead output FIFO.
// Define CONV_POSTPROC_LEAKY_EN to build the leaky ReLU multiplier; otherwise S1 is a plain register.
module conv_postproc #(
  parameter int LANES         = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int ALMOST_MARGIN = 6,
  parameter int LEAKY_NUM     = 13
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid_in,
  input  logic [LANES*32-1:0]           acc_in,
  input  logic                          relu_en,
  input  logic [15:0]                   scale_mult,
  input  logic [4:0]                    scale_shift,
  input  logic [7:0]                    zero_point,
  output logic [LANES*8-1:0]            m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          almost_full,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  // valid_reg[0]: input captured, [1]: S1 done, [2]: S2 done, [3]: S3 byte ready to write
  logic [3:0]           valid_reg;
  logic [LANES*8-1:0]   word_s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= '0;
    end else begin
      valid_reg <= {valid_reg[2:0], valid_in};
    end
  end

`ifndef CONV_POSTPROC_LEAKY_EN
  logic relu_en_unused;
  assign relu_en_unused = relu_en;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [31:0] x_reg;
      logic signed [31:0] y_reg;
      logic signed [31:0] y_next;
      logic signed [48:0] p_reg;
      logic signed [48:0] y_ext;
      logic signed [48:0] m_ext;
      logic signed [50:0] p_ext;
      logic signed [50:0] rnd;
      logic signed [50:0] q;
      logic signed [50:0] r;
      logic [7:0]         byte_next;
      logic [7:0]         byte_reg;

      always_ff @(posedge clk) begin
        x_reg <= acc_in[gi*32 +: 32];
      end

`ifdef CONV_POSTPROC_LEAKY_EN
      localparam logic signed [39:0] LEAKY_C = 40'(LEAKY_NUM);
      logic signed [39:0] x_ext;
      logic signed [39:0] leaky_prod;

      always_comb begin
        x_ext      = {{8{x_reg[31]}}, x_reg};
        leaky_prod = x_ext * LEAKY_C;
        // arithmetic shift floors toward minus infinity, matching the integer slope model
        y_next     = (relu_en && x_reg[31]) ? 32'(leaky_prod >>> 7) : x_reg;
      end
`else
      always_comb begin
        y_next = x_reg;
      end
`endif

      always_ff @(posedge clk) begin
        y_reg <= y_next;
      end

      always_comb begin
        y_ext = {{17{y_reg[31]}}, y_reg};
        m_ext = {33'b0, scale_mult};
      end

      always_ff @(posedge clk) begin
        p_reg <= y_ext * m_ext;
      end

      always_comb begin
        p_ext = {{2{p_reg[48]}}, p_reg};
        rnd   = (scale_shift == 5'd0) ? '0 : (51'sd1 <<< (scale_shift - 5'd1));
        q     = (p_ext + rnd) >>> scale_shift;
        r     = q + $signed({43'b0, zero_point});
        if (r[50]) begin
          byte_next = 8'd0;
        end else if (|r[49:8]) begin
          byte_next = 8'd255;
        end else begin
          byte_next = r[7:0];
        end
      end

      always_ff @(posedge clk) begin
        byte_reg <= byte_next;
      end

      assign word_s3[gi*8 +: 8] = byte_reg;
    end
  endgenerate

  // Output FIFO: asynchronous head read so a word written on one edge is visible right after it.
  logic [LANES*8-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_reg;
  logic [AW-1:0]      rd_ptr_reg;
  logic [CW-1:0]      count_reg;
  logic [CW-1:0]      count_next;
  logic               overflow_reg;
  logic               almost_full_reg;
  logic               full;
  logic               pop;
  logic               push;
  logic               drop;

  always_comb begin
    full = (count_reg == CW'(FIFO_DEPTH));
    pop  = (count_reg != '0) && m_ready;
    push = valid_reg[3] && (!full || pop);
    drop = valid_reg[3] && full && !pop;
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + 1'b1;
    end else if (!push && pop) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= word_s3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      overflow_reg    <= 1'b0;
      almost_full_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg       <= count_next;
      almost_full_reg <= (count_next >= CW'(FIFO_DEPTH - ALMOST_MARGIN));
      if (drop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign m_valid     = (count_reg != '0);
  assign m_data      = m_valid ? mem[rd_ptr_reg] : '0;
  assign fifo_count  = count_reg;
  assign almost_full = almost_full_reg;
  assign overflow    = overflow_reg;

endmodule

// File: tb/tb_conv_postproc.sv
// Directed self-checking bench for conv_postproc; expected words are hand-computed constants.
module tb_conv_postproc;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_in;
  logic [255:0] acc_in;
  logic         relu_en;
  logic [15:0]  scale_mult;
  logic [4:0]   scale_shift;
  logic [7:0]   zero_point;
  logic [63:0]  m_data;
  logic         m_valid;
  logic         m_ready;
  logic         almost_full;
  logic         overflow;
  logic [4:0]   fifo_count;

  int tests_run    = 0;
  int tests_failed = 0;

`ifdef CONV_POSTPROC_LEAKY_EN
  localparam logic [63:0] EXP_LEAKY = 64'h808080808073E477;
`else
  localparam logic [63:0] EXP_LEAKY = 64'h808080808000E430;
`endif

  always #5 clk = ~clk;

  conv_postproc dut (
    .clk         (clk),
    .rst         (rst),
    .valid_in    (valid_in),
    .acc_in      (acc_in),
    .relu_en     (relu_en),
    .scale_mult  (scale_mult),
    .scale_shift (scale_shift),
    .zero_point  (zero_point),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .almost_full (almost_full),
    .overflow    (overflow),
    .fifo_count  (fifo_count)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", tag, observed, expected);
    end else begin
      $display("[TB] ok %s = %h", tag, observed);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] pack8(input int l0, input int l1, input int l2, input int l3,
                                         input int l4, input int l5, input int l6, input int l7);
    return {32'(l7), 32'(l6), 32'(l5), 32'(l4), 32'(l3), 32'(l2), 32'(l1), 32'(l0)};
  endfunction

  task automatic set_cfg(input logic re, input logic [15:0] m, input logic [4:0] s, input logic [7:0] zp);
    relu_en     = re;
    scale_mult  = m;
    scale_shift = s;
    zero_point  = zp;
  endtask

  task automatic send(input logic [255:0] a);
    valid_in = 1'b1;
    acc_in   = a;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!m_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_vld"}, 64'(m_valid), 64'd1);
  endtask

  // Waits for the head word, checks it, and lets it pop (m_ready must be high).
  task automatic expect_word(input string tag, input logic [63:0] exp);
    wait_valid(tag);
    check(tag, m_data, exp);
    tick();
  endtask

  initial begin
    int stale;
    rst = 1'b1;
    valid_in = 1'b0;
    acc_in = '0;
    m_ready = 1'b1;
    set_cfg(1'b0, 16'd1, 5'd0, 8'd0);
    repeat (3) tick();
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data", m_data, 64'd0);
    check("rst_almost_full", 64'(almost_full), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_count", 64'(fifo_count), 64'd0);
    rst = 1'b0;
    tick();

    // Identity and exact 4-cycle latency
    send(pack8(0, 1, 2, 3, 4, 5, 6, 7));
    repeat (3) tick();
    check("ident_early", 64'(m_valid), 64'd0);
    tick();
    check("ident_lat", 64'(m_valid), 64'd1);
    check("ident_data", m_data, 64'h0706050403020100);
    tick();
    check("ident_count", 64'(fifo_count), 64'd0);

    // Saturation
    send(pack8(300, -5, 255, 256, 0, 1, -1, 32'h7fffffff));
    expect_word("saturate", 64'hFF000100FFFF00FF);

    // Leaky ReLU with zero point, then the same input with relu disabled
    set_cfg(1'b1, 16'd1, 5'd0, 8'd128);
    send(pack8(-80, 100, -128, 0, 0, 0, 0, 0));
    expect_word("leaky_on", EXP_LEAKY);
    set_cfg(1'b0, 16'd1, 5'd0, 8'd128);
    send(pack8(-80, 100, -128, 0, 0, 0, 0, 0));
    expect_word("leaky_off", 64'h808080808000E430);

    // Round-half-up shift
    set_cfg(1'b0, 16'd3, 5'd2, 8'd0);
    send(pack8(5, 6, -5, 1, 100, 0, 0, 0));
    expect_word("round", 64'h0000004B01000504);

    // Maximum shift with unsigned full-scale multiplier
    set_cfg(1'b0, 16'hFFFF, 5'd31, 8'd0);
    send(pack8(32768, 16384, 0, 0, 0, 0, 0, 0));
    expect_word("shift31", 64'h0000000000000001);

    // Backpressure: 17 words into a 16-deep FIFO
    set_cfg(1'b0, 16'd1, 5'd0, 8'd0);
    m_ready = 1'b0;
    for (int c = 0; c < 25; c++) begin
      if (c < 17) begin
        valid_in = 1'b1;
        acc_in   = {8{32'(c + 1)}};
      end else begin
        valid_in = 1'b0;
      end
      tick();
      if (fifo_count == 5'd9)  check("af_below", 64'(almost_full), 64'd0);
      if (fifo_count == 5'd10) check("af_at", 64'(almost_full), 64'd1);
      if (fifo_count == 5'd15) check("ovf_early", 64'(overflow), 64'd0);
    end
    check("bp_count", 64'(fifo_count), 64'd16);
    check("bp_overflow", 64'(overflow), 64'd1);
    check("bp_almost_full", 64'(almost_full), 64'd1);
    m_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      expect_word("drain", {8{8'(k)}});
    end
    repeat (3) tick();
    check("drain_no17", 64'(m_valid), 64'd0);
    check("drain_count", 64'(fifo_count), 64'd0);
    check("drain_ovf_sticky", 64'(overflow), 64'd1);
    check("drain_af", 64'(almost_full), 64'd0);

    // Full FIFO with a pop in the same cycle as a write
    m_ready = 1'b0;
    for (int k = 8'h21; k <= 8'h30; k++) begin
      send({8{32'(k)}});
    end
    repeat (6) tick();
    check("full_count", 64'(fifo_count), 64'd16);
    send({8{32'h31}});
    repeat (3) tick();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("fullpop_count", 64'(fifo_count), 64'd16);
    check("fullpop_head", m_data, {8{8'h22}});
    m_ready = 1'b1;
    for (int k = 8'h22; k <= 8'h31; k++) begin
      expect_word("fullpop_drain", {8{8'(k)}});
    end

    // Mid-stream reset discards FIFO and in-flight words
    m_ready = 1'b0;
    repeat (3) send({8{32'h50}});
    send({8{32'h51}});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_m_valid", 64'(m_valid), 64'd0);
    check("mrst_count", 64'(fifo_count), 64'd0);
    check("mrst_overflow", 64'(overflow), 64'd0);
    check("mrst_almost_full", 64'(almost_full), 64'd0);
    m_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (m_valid) stale++;
    end
    check("mrst_stale", 64'(stale), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
